// File: rtl/div_unit_if.sv
// rtl/div_unit_if.sv - request/result bundle for div_unit
interface div_unit_if #(parameter int WIDTH = 32);
   logic             start;
   logic             sign_mode;
   logic [WIDTH-1:0] dividend;
   logic [WIDTH-1:0] divisor;
   logic [WIDTH-1:0] q;
   logic [WIDTH-1:0] r;
   logic             busy;
   logic             done;
   logic             div_zero;

   modport master (
      output start, sign_mode, dividend, divisor,
      input  q, r, busy, done, div_zero
   );

   modport slave (
      input  start, sign_mode, dividend, divisor,
      output q, r, busy, done, div_zero
   );
endinterface

// File: rtl/div_unit.sv
// rtl/div_unit.sv - radix-2 restoring signed/unsigned divider, WIDTH steps per result
// Optional: DIV_ZERO_FAST_EN resolves a zero divisor in one cycle without entering RUN.
module div_unit #(
   parameter int WIDTH = 32
) (
   input  logic       clock,
   input  logic       reset,
   div_unit_if.slave  bus
);
   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, RUN, FIN} state_t;

   state_t           state;
   state_t           state_next;
   logic [WIDTH-1:0] rem;
   logic [WIDTH-1:0] quo;
   logic [WIDTH-1:0] dvs;
   logic [CW-1:0]    cnt;
   logic             q_neg;
   logic             r_neg;
   logic             zero;

   logic             accept;
   logic             last;
   logic             fast_zero;
   logic             a_neg;
   logic             b_neg;
   logic [WIDTH-1:0] a_mag;
   logic [WIDTH-1:0] b_mag;
   logic [WIDTH:0]   up;
   logic             ge;
   logic [WIDTH-1:0] rem_step;
   logic [WIDTH-1:0] quo_step;
   logic [WIDTH-1:0] q_fin;
   logic [WIDTH-1:0] r_fin;

   assign accept = (state == IDLE) && bus.start;
   assign last   = (state == RUN) && (cnt == CW'(WIDTH - 1));

`ifdef DIV_ZERO_FAST_EN
   assign fast_zero = (bus.divisor == '0);
`else
   assign fast_zero = 1'b0;
`endif

   assign a_neg = bus.sign_mode & bus.dividend[WIDTH-1];
   assign b_neg = bus.sign_mode & bus.divisor[WIDTH-1];
   assign a_mag = a_neg ? -bus.dividend : bus.dividend;
   assign b_mag = b_neg ? -bus.divisor  : bus.divisor;

   // Partial remainder keeps a carry bit so divisors near 2^WIDTH compare correctly
   assign up       = {rem, quo[WIDTH-1]};
   assign ge       = (up >= {1'b0, dvs});
   assign rem_step = ge ? (up[WIDTH-1:0] - dvs) : up[WIDTH-1:0];
   assign quo_step = {quo[WIDTH-2:0], ge};

   // Zero divisor leaves the dividend magnitude in rem, so sign correction restores it
   assign q_fin = zero  ? '1 : (q_neg ? -quo_step : quo_step);
   assign r_fin = r_neg ? -rem_step : rem_step;

   always_ff @(posedge clock) begin
      if (reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (bus.start) state_next = fast_zero ? FIN : RUN;
         RUN:     if (last) state_next = IDLE;
         FIN:     state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      bus.busy = (state == RUN);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         rem          <= '0;
         quo          <= '0;
         dvs          <= '0;
         cnt          <= '0;
         q_neg        <= 1'b0;
         r_neg        <= 1'b0;
         zero         <= 1'b0;
         bus.q        <= '0;
         bus.r        <= '0;
         bus.div_zero <= 1'b0;
         bus.done     <= 1'b0;
      end else begin
         bus.done <= 1'b0;
         if (accept) begin
            rem   <= '0;
            quo   <= fast_zero ? bus.dividend : a_mag;
            dvs   <= b_mag;
            q_neg <= a_neg ^ b_neg;
            r_neg <= a_neg;
            zero  <= (bus.divisor == '0);
            cnt   <= '0;
         end else if (state == RUN) begin
            rem <= rem_step;
            quo <= quo_step;
            cnt <= cnt + CW'(1);
            if (last) begin
               bus.q        <= q_fin;
               bus.r        <= r_fin;
               bus.div_zero <= zero;
               bus.done     <= 1'b1;
            end
         end else if (state == FIN) begin
            bus.q        <= '1;
            bus.r        <= quo;
            bus.div_zero <= 1'b1;
            bus.done     <= 1'b1;
         end
      end
   end
endmodule

// File: doc/div_unit.md
# div_unit

Parametrised multi-cycle integer divider for the CPU's multiply/divide path, next generation of the fixed 32-bit signed divider. Handles both signed (DIV) and unsigned (DIVU) operation under a per-request mode bit and flags divide-by-zero. It provides a one-cycle completion pulse so the pipeline stall logic can release on a single signal rather than watching `busy` fall. It uses a radix-2 restoring algorithm on operand magnitudes, with sign correction applied at completion.

## Interface
- `WIDTH`, 32, operand/result width in bits; legal values 8..64.
- `clock`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high reset.
- `start`  in  1  request strobe; sampled only while idle (`busy`=0).
- `sign_mode`  in  1  1 = signed (two's complement) divide; 0 = unsigned.
- `dividend`  in  WIDTH  dividend; captured on the accepting edge.
- `divisor`  in  WIDTH  divisor; captured on the accepting edge.
- `q`  out  WIDTH  quotient; registered; reset 0.
- `r`  out  WIDTH  remainder; registered; reset 0.
- `busy`  out  1  operation in progress; reset 0.
- `done`  out  1  one-cycle completion pulse; reset 0.
- `div_zero`  out  1  last completed operation had divisor 0; registered with `q`/`r`; reset 0.

## Operation
- States: IDLE, RUN, plus FIN if needed internally. `busy`=1 exactly in RUN.
- IDLE with `start`=1 on an edge:
  - Latch magnitudes: signed mode takes |x|; unsigned mode takes the raw value.
  - Latch the quotient sign (dividend sign XOR divisor sign, signed mode only) and the remainder sign (dividend sign, signed mode only).
  - Latch the divisor-zero flag, clear the iteration counter, and enter RUN.
- RUN, one restoring step per cycle:
  - Shift the {rem, quo} register (2·WIDTH bits) left one bit.
  - If the upper half is ≥ the divisor magnitude, subtract the divisor and set quo[0].
  - The counter is ceil(log2(WIDTH+1)) bits wide. After WIDTH steps, finish.
- Finish: apply two's-complement negation per the latched signs, write `q`, `r` and `div_zero`, pulse `done`, and return to IDLE.
- Result rules:
  - Quotient truncates toward zero; remainder takes the sign of the dividend.
  - Signed most-negative / −1: `q` = most-negative (wraps), `r` = 0, no flag.
  - Divisor 0, either mode: `q` = all ones, `r` = original dividend, `div_zero`=1.
- Inputs are ignored while busy. `start` during RUN is dropped and is not queued.
- `q`/`r`/`div_zero` hold their values until the next completion; they are not cleared at start.

## Timing
- `start` accepted at edge N: `busy`=1 after N, through edge N+WIDTH.
- At edge N+WIDTH: `q`/`r`/`div_zero` update, `busy`→0, and `done`=1 for exactly one cycle.
- Latency is WIDTH cycles, start to `done`.
- Back-to-back: a `start` sampled in the `done` cycle is accepted, so one result issues every WIDTH+1 cycles.
- `reset` has priority over everything. In any state it returns the block to IDLE next edge with all outputs 0 and aborts any in-flight operation; nothing is produced for the aborted request.

## Configuration
- `DIV_ZERO_FAST_EN`:
  - Defined: a zero divisor bypasses RUN. The result (`q` = all ones, `r` = dividend, `div_zero`=1) is written and `done` pulses at edge N+1, and `busy` never asserts.
  - Undefined: a zero divisor runs the full WIDTH cycles like any other operand and produces the same values at edge N+WIDTH.

## Test plan
- WIDTH=32, signed, 100 / 7 → `q`=14, `r`=2, `done` exactly 32 cycles after accept, `busy` high 32 cycles.
- Signed −100 / 7 → `q`=0xFFFFFFF2, `r`=0xFFFFFFFE. Signed 100 / −7 → `q`=0xFFFFFFF2, `r`=2.
- Unsigned 0xFFFFFFFF / 2 → `q`=0x7FFFFFFF, `r`=1. The same operands in signed mode (−1 / 2) → `q`=0, `r`=0xFFFFFFFF.
- Signed 0x80000000 / 0xFFFFFFFF → `q`=0x80000000, `r`=0, `div_zero`=0. Then 5 / 0 → `q`=0xFFFFFFFF, `r`=5, `div_zero`=1, with `done` at cycle 1 (macro defined) or cycle 32 (macro undefined).
- `start` re-pulsed with new operands mid-RUN → ignored, and the original result is delivered. A `start` in the `done` cycle → accepted, with a second `done` 32 cycles later.
- `reset` asserted at step 10 → next edge: `busy`=0, `q`=`r`=0, no `done`. A new request afterwards completes correctly. Repeat with WIDTH=8: 200 / 3 unsigned → `q`=66, `r`=2 after 8 cycles.
